alu_serial: RTL and testbench

Parametrised digit-serial ALU. It performs the same four 2-bit-coded operations as the team's combinational ripple ALU, but processes `DIGIT` bits per clock over a `WIDTH`-bit word, so width and area/latency trade-off are generic. Operands enter and results leave through valid/ready handshakes, and the block adds zero and signed-overflow flags. It sits between the datapath register file and the writeback stage wherever a full-width ripple chain is too slow or too large.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_digit.sv | 40 ++++
 rtl/alu_serial.sv | 174 +++++++++++++++++
 tb/tb_alu_serial.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU family.
//   alu_op_e    : 2-bit operation code (NOR, XOR, ADD, SUB)
//   alu_state_e : control states of the digit-serial ALU
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // ADD and SUB share the code MSB; only they use the carry chain.
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice, usable on its own or chained.
//   a, b : DIGIT-bit operand digits
//   cin  : carry into the digit (used by ADD/SUB only)
//   op   : operation code (alu_op_e encoding)
//   s    : DIGIT-bit result digit
//   cout : carry out of the digit MSB, 0 for NOR/XOR
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        s     = '0;
        cout  = 1'b0;
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
        case (op)
            OP_NOR: s = ~(a | b);
            OP_XOR: s = a ^ b;
            default: begin
                s    = sum[DIGIT-1:0];
                cout = sum[DIGIT];
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: NOR/XOR/ADD/SUB over a WIDTH-bit word, DIGIT bits per
// clock, LSB digit first, with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin, op       : operands, captured on acceptance
//   out_valid, out_ready: result handshake (result held until taken)
//   s, cout, zero, ovf  : registered result and flags
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic [WIDTH-1:0] res_next;
    logic             last_digit;
    logic             bp_msb;
    logic             ovf_next;

    // Operand shift registers present the current digit in their low bits.
    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // Result digits enter at the top and move down, so after N digits the
    // first (least significant) digit sits at bit 0.
    assign res_next   = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // On the last digit the slice sees the word MSBs, so the sign bits of
    // a, b' and s are all available here for the overflow term.
    assign bp_msb   = b_q[DIGIT-1] ^ (op_q == OP_SUB);
    assign ovf_next = is_arith(op_q) & (a_q[DIGIT-1] ^ bp_msb ^ dig_s[DIGIT-1] ^ dig_cout);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        op_d        = op_q;
        carry_d     = carry_q;
        s_d         = s_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RUN;
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    carry_d    = cin & is_arith(op);
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                res_d   = res_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d     = DONE;
                    s_d         = res_next;
                    cout_d      = dig_cout & is_arith(op_q);
                    zero_d      = (res_next == '0);
                    ovf_d       = ovf_next;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (checked inside the clocked block) and
        // clears the datapath too, so an abandoned operation leaves no trace.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= 2'b00;
            carry_q     <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (64/8, 8/8, 12/4) driven in
// lockstep, checked against an arithmetic reference model and a table of
// hand-computed 64-bit results.
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a, b;
    logic        cin;
    logic [1:0]  op;

    logic [2:0]  in_rdy, out_vld, cout_o, zero_o, ovf_o;
    logic [63:0] s64;
    logic [7:0]  s8;
    logic [11:0] s12;
    logic [63:0] s_arr [3];

    int total = 0;
    int bad   = 0;

    int width [3] = '{64, 8, 12};
    int lat   [3] = '{9, 2, 4};

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(64), .DIGIT(8)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_vld[0]),
        .out_ready(out_ready), .s(s64), .cout(cout_o[0]), .zero(zero_o[0]), .ovf(ovf_o[0])
    );

    alu_serial #(.WIDTH(8), .DIGIT(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op), .out_valid(out_vld[1]),
        .out_ready(out_ready), .s(s8), .cout(cout_o[1]), .zero(zero_o[1]), .ovf(ovf_o[1])
    );

    alu_serial #(.WIDTH(12), .DIGIT(4)) u_w12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .a(a[11:0]), .b(b[11:0]), .cin(cin), .op(op), .out_valid(out_vld[2]),
        .out_ready(out_ready), .s(s12), .cout(cout_o[2]), .zero(zero_o[2]), .ovf(ovf_o[2])
    );

    always_comb begin
        s_arr[0] = s64;
        s_arr[1] = 64'(s8);
        s_arr[2] = 64'(s12);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on a w-bit word; overflow is
    // "operands of equal sign give a result of the other sign".
    function automatic void model(input int w, input logic [1:0] opc,
                                  input logic [63:0] x, input logic [63:0] y, input logic ci,
                                  output logic [63:0] rs, output logic rc, output logic rz,
                                  output logic rv);
        logic [64:0] mask, xm, ym, sum;
        mask = (65'd1 << w) - 65'd1;
        xm   = {1'b0, x} & mask;
        ym   = {1'b0, y} & mask;
        rc   = 1'b0;
        rv   = 1'b0;
        sum  = '0;
        case (opc)
            2'b00: rs = 64'(~(xm | ym) & mask);
            2'b01: rs = 64'(xm ^ ym);
            default: begin
                if (opc == 2'b11) ym = ~ym & mask;
                sum = xm + ym + 65'(ci);
                rs  = 64'(sum & mask);
                rc  = sum[w];
                rv  = (xm[w-1] == ym[w-1]) && (rs[w-1] != xm[w-1]);
            end
        endcase
        rz = (rs == 64'd0);
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // One operation through all three instances. Checks latency, results,
    // optional backpressure hold, and the return to IDLE.
    task automatic do_op(input logic [1:0] op_i, input logic [63:0] a_i, input logic [63:0] b_i,
                         input logic cin_i, input int hold,
                         output logic [63:0] s0, output logic [2:0] f0);
        int          first [3];
        logic [63:0] es, hs [3];
        logic        ec, ez, ev;
        logic [2:0]  hf [3];

        @(negedge clk);
        check("in_ready_idle", 64'(in_rdy), 64'h7);
        in_valid  = 1'b1;
        a         = a_i;
        b         = b_i;
        cin       = cin_i;
        op        = op_i;
        out_ready = 1'b0;
        @(negedge clk);
        // Scramble inputs after acceptance: captured operands must not move.
        in_valid = 1'b0;
        a        = rand64();
        b        = rand64();
        cin      = ~cin_i;
        op       = 2'($urandom());
        first    = '{-1, -1, -1};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            for (int i = 0; i < 3; i++)
                if (out_vld[i] && first[i] < 0) first[i] = cyc;
            if (out_vld == 3'b111) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            model(width[i], op_i, a_i, b_i, cin_i, es, ec, ez, ev);
            check($sformatf("latency_w%0d", width[i]), 64'(first[i]), 64'(lat[i]));
            check($sformatf("s_w%0d", width[i]), s_arr[i], es);
            check($sformatf("flags_w%0d", width[i]),
                  64'({cout_o[i], zero_o[i], ovf_o[i]}), 64'({ec, ez, ev}));
            hs[i] = s_arr[i];
            hf[i] = {cout_o[i], zero_o[i], ovf_o[i]};
        end
        check("in_ready_busy", 64'(in_rdy), 64'h0);
        s0 = s64;
        f0 = {cout_o[0], zero_o[0], ovf_o[0]};

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom());
            a        = rand64();
            b        = rand64();
            @(negedge clk);
            check("hold_valid", 64'(out_vld), 64'h7);
            check("hold_in_ready", 64'(in_rdy), 64'h0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("hold_s_w%0d", width[i]), s_arr[i], hs[i]);
                check($sformatf("hold_flags_w%0d", width[i]),
                      64'({cout_o[i], zero_o[i], ovf_o[i]}), 64'(hf[i]));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_done", 64'(in_rdy), 64'h7);
        check("valid_after_done", 64'(out_vld), 64'h0);
        @(negedge clk);
        check("no_extra_result", 64'(out_vld), 64'h0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a, b;
        logic        cin;
        logic [63:0] s;
        logic [2:0]  flags;  // {cout, zero, ovf}
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [63:0] rs;
        logic [2:0]  rf;

        vecs[0] = '{2'b10, '1, 64'd1, 1'b0, 64'd0, 3'b110};
        vecs[1] = '{2'b11, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000};
        vecs[2] = '{2'b11, 64'd7, 64'd5, 1'b1, 64'd2, 3'b100};
        vecs[3] = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 3'b001};
        vecs[4] = '{2'b00, 64'd0, 64'd0, 1'b0, '1, 3'b000};
        vecs[5] = '{2'b01, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'd0, 3'b010};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_rdy), 64'h7);
        check("reset_out_valid", 64'(out_vld), 64'h0);
        for (int i = 0; i < 3; i++) check($sformatf("reset_s_w%0d", width[i]), s_arr[i], 64'd0);
        check("reset_flags", 64'({cout_o, zero_o, ovf_o}), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            do_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].cin, 0, rs, rf);
            check($sformatf("table%0d_s", k), rs, vecs[k].s);
            check($sformatf("table%0d_flags", k), 64'(rf), 64'(vecs[k].flags));
        end

        // Random operations; the first one sits in DONE under backpressure.
        for (int k = 0; k < 30; k++)
            do_op(2'($urandom()), rand64(), rand64(), 1'($urandom()),
                  (k == 0) ? 5 : int'($urandom_range(0, 2)), rs, rf);

        // Reset in RUN cycle 4 (the narrow instances are already in DONE).
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b10;
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        cin      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_rst_in_ready", 64'(in_rdy), 64'h7);
        check("midrun_rst_out_valid", 64'(out_vld), 64'h0);
        for (int i = 0; i < 3; i++) check($sformatf("midrun_rst_s_w%0d", width[i]), s_arr[i], 64'd0);
        check("midrun_rst_flags", 64'({cout_o, zero_o, ovf_o}), 64'd0);
        repeat (10) @(negedge clk);
        check("abandoned_no_result", 64'(out_vld), 64'h0);
        do_op(2'b10, 64'd3, 64'd4, 1'b0, 0, rs, rf);
        check("post_reset_add", rs, 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
